// File: rtl/multiword_add_seq_pkg.sv
// Shared constants and state type for the byte-serial multi-precision add/subtract sequencer.
package multiword_add_seq_pkg;

    localparam int SLICE_W = 8;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/multiword_add_seq_adder_8bit.sv
// Plain 8-bit ripple adder with carry in/out; the single arithmetic unit time-shared by the sequencer.
module adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c_in,
    output logic [7:0] sum,
    output logic       c_out
);

    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {8'b0000_0000, c_in};

endmodule

// File: rtl/multiword_add_seq.sv
// Multi-precision add/subtract: walks WORDS byte slices LSB first through one shared 8-bit adder,
// holding the inter-slice carry in a register, with valid/ready handshakes on both sides.
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter  int WORDS = 4,
    localparam int W     = SLICE_W * WORDS,
    localparam int CNT_W = $clog2(WORDS)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         sub,
    input  logic         C_in,
    output logic [W-1:0] S,
    output logic         C_out,
    output logic         V,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       s_q, s_d;
    logic               c_out_q, c_out_d;
    logic               v_q, v_d;

    logic [SLICE_W-1:0] a_slice;
    logic [SLICE_W-1:0] b_slice;
    logic [SLICE_W-1:0] add_sum;
    logic               add_cout;

    assign a_slice = a_q[SLICE_W*cnt_q +: SLICE_W];
    assign b_slice = b_q[SLICE_W*cnt_q +: SLICE_W];

    adder_8bit u_adder (
        .a     (a_slice),
        .b     (b_slice),
        .c_in  (carry_q),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    // Next-state logic: accept in IDLE (subtract becomes A + ~B + 1), one slice per RUN cycle, hold in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        c_out_d = c_out_q;
        v_d     = v_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = sub ? ~B : B;
                    carry_d = sub ? 1'b1 : C_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[SLICE_W*cnt_q +: SLICE_W] = add_sum;
                carry_d = add_cout;
                if (cnt_q == LAST_CNT) begin
                    c_out_d = add_cout;
                    v_d     = (a_q[W-1] == b_q[W-1]) && (add_sum[SLICE_W-1] != a_q[W-1]);
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; synchronous reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            c_out_q <= c_out_d;
            v_q     <= v_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign S         = s_q;
    assign C_out     = c_out_q;
    assign V         = v_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Scoreboard bench for multiword_add_seq (WORDS = 4): directed operands push expected results,
// a negedge monitor pops and compares whenever a result handshake is about to complete.
module tb_multiword_add_seq;

    localparam int WORDS = 4;
    localparam int W     = 8 * WORDS;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         sub;
    logic         C_in;
    logic [W-1:0] S;
    logic         C_out;
    logic         V;
    logic         out_valid;
    logic         out_ready;

    exp_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    multiword_add_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .sub       (sub),
        .C_in      (C_in),
        .S         (S),
        .C_out     (C_out),
        .V         (V),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: a result is consumed at the next posedge whenever out_valid and out_ready are both high.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_result: got S=0x%0h, expected no result", S);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("S", 64'(S), 64'(e.s));
                checkOutput("C_out", 64'(C_out), 64'(e.c));
                checkOutput("V", 64'(V), 64'(e.v));
            end
        end
    end

    // Issue one request, optionally record its expected result, check latency and wait for consumption.
    task automatic applyStimulus(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input logic sub_v,
                                 input logic cin_v, input logic [W-1:0] exp_s, input logic exp_c,
                                 input logic exp_v, input bit wait_consume);
        int cycles;
        cycles = 0;
        while (!in_ready && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("in_ready_before_issue", 64'(in_ready), 64'd1);
        sb_q.push_back('{s: exp_s, c: exp_c, v: exp_v});
        in_valid = 1'b1;
        A        = a_v;
        B        = b_v;
        sub      = sub_v;
        C_in     = cin_v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A        = ~a_v;
        B        = ~b_v;
        sub      = ~sub_v;
        C_in     = ~cin_v;
        cycles   = 0;
        while (cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
            if (out_valid) break;
        end
        checkOutput("latency", 64'(cycles), 64'(WORDS));
        if (wait_consume) begin
            cycles = 0;
            while (out_valid && cycles < 20) begin
                @(posedge clk); #1;
                cycles++;
            end
            checkOutput("consumed", 64'(out_valid), 64'd0);
        end
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        sub       = 1'b0;
        C_in      = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_S", 64'(S), 64'd0);
        checkOutput("rst_C_out", 64'(C_out), 64'd0);
        checkOutput("rst_V", 64'(V), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0101, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
        applyStimulus(32'h0000_0010, 32'h0000_0003, 1'b1, 1'b0, 32'h0000_000D, 1'b1, 1'b0, 1'b1);
        applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);

        // Backpressure: hold the result for 10 cycles while the requester keeps poking.
        out_ready = 1'b0;
        applyStimulus(32'h0000_1234, 32'h0000_4321, 1'b0, 1'b0, 32'h0000_5555, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            A        = 32'hA5A5_0000 + 32'(i);
            B        = 32'h5A5A_0000 + 32'(i);
            @(posedge clk); #1;
            checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
            checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
            checkOutput("stall_S", 64'(S), 64'h5555);
            checkOutput("stall_C_out", 64'(C_out), 64'd0);
            checkOutput("stall_V", 64'(V), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("release_out_valid", 64'(out_valid), 64'd0);
        checkOutput("release_in_ready", 64'(in_ready), 64'd1);

        // Reset during the second RUN cycle aborts the operation.
        in_valid = 1'b1;
        A        = 32'h0000_00AA;
        B        = 32'h0000_0011;
        sub      = 1'b0;
        C_in     = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
        checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
        checkOutput("abort_S", 64'(S), 64'd0);
        checkOutput("abort_C_out", 64'(C_out), 64'd0);
        checkOutput("abort_V", 64'(V), 64'd0);

        applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_left", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
